// File: rtl/sdram_chip_model.sv
// rtl/sdram_chip_model.sv - pin-level 16-bit SDR SDRAM target model with protocol checking
module sdram_chip_model #(
  parameter int MEM_AW = 16,
  parameter int TRCD   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sdram_cke,
  input  logic        sdram_ncs,
  input  logic        sdram_nras,
  input  logic        sdram_ncas,
  input  logic        sdram_nwe,
  input  logic [1:0]  sdram_ba,
  input  logic [12:0] sdram_a,
  input  logic        sdram_dqml,
  input  logic        sdram_dqmh,
  input  logic [15:0] sdram_dq_in,
  output logic [15:0] sdram_dq_out,
  output logic        sdram_dq_oe,
  output logic [12:0] mode_reg,
  output logic        init_done,
  output logic [5:0]  err_flags,
  output logic [15:0] refresh_cnt
);

  localparam int          DEPTH   = 1 << MEM_AW;
  localparam logic [3:0]  TRCD_M1 = 4'(TRCD - 1);
  localparam logic [3:0]  CMD_ACT = 4'b0011;
  localparam logic [3:0]  CMD_RD  = 4'b0101;
  localparam logic [3:0]  CMD_WR  = 4'b0100;
  localparam logic [3:0]  CMD_PRE = 4'b0010;
  localparam logic [3:0]  CMD_REF = 4'b0001;
  localparam logic [3:0]  CMD_LMR = 4'b0000;

  // Backing store; deliberately survives reset like real DRAM contents.
  logic [15:0] mem [0:DEPTH-1];

  logic [3:0]  bank_active;
  logic [12:0] bank_row [4];
  logic [3:0]  trcd_cnt [4];
  logic        init_armed;

  // Read pipe: slot 0 is presented on the next edge.
  logic [15:0] pipe_data [3];
  logic [2:0]  pipe_vld;

  logic [3:0]        cmd;
  logic              is_act, is_rd, is_wr, is_pre, is_ref, is_lmr;
  logic              sel_active;
  logic [12:0]       sel_row;
  logic [MEM_AW-1:0] mem_idx;
  logic              do_rd, do_wr;
  logic [1:0]        ins_slot;
  logic [15:0]       rd_word;

  // Command decode and address formation for the addressed bank.
  always_comb begin
    cmd        = {sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe};
    is_act     = sdram_cke && (cmd == CMD_ACT);
    is_rd      = sdram_cke && (cmd == CMD_RD);
    is_wr      = sdram_cke && (cmd == CMD_WR);
    is_pre     = sdram_cke && (cmd == CMD_PRE);
    is_ref     = sdram_cke && (cmd == CMD_REF);
    is_lmr     = sdram_cke && (cmd == CMD_LMR);
    sel_active = bank_active[sdram_ba];
    sel_row    = bank_row[sdram_ba];
    mem_idx    = MEM_AW'({sdram_ba, sel_row, sdram_a[8:0]});
    do_rd      = is_rd && sel_active;
    do_wr      = is_wr && sel_active;
    // CL3 parks the word one slot further back; anything else behaves as CL2.
    ins_slot   = (mode_reg[6:4] == 3'd3) ? 2'd1 : 2'd0;
    rd_word    = mem[mem_idx];
  end

  // Byte-masked array write on the command edge.
  always_ff @(posedge clk) begin
    if (!reset && do_wr) begin
      if (!sdram_dqml) mem[mem_idx][7:0]  <= sdram_dq_in[7:0];
      if (!sdram_dqmh) mem[mem_idx][15:8] <= sdram_dq_in[15:8];
    end
  end

  // Per-bank open-row tracking and tRCD countdown.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_active <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        bank_row[i] <= 13'd0;
        trcd_cnt[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (trcd_cnt[i] != 4'd0) trcd_cnt[i] <= trcd_cnt[i] - 4'd1;
      end
      if (is_act) begin
        bank_active[sdram_ba] <= 1'b1;
        bank_row[sdram_ba]    <= sdram_a;
        trcd_cnt[sdram_ba]    <= TRCD_M1;
      end else if (is_pre) begin
        if (sdram_a[10]) bank_active <= 4'b0000;
        else             bank_active[sdram_ba] <= 1'b0;
      end else if ((do_rd || do_wr) && sdram_a[10]) begin
        bank_active[sdram_ba] <= 1'b0;
      end
    end
  end

  // Mode register, init sequence, refresh counting and sticky violation flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_reg    <= 13'd0;
      init_armed  <= 1'b0;
      init_done   <= 1'b0;
      err_flags   <= 6'd0;
      refresh_cnt <= 16'd0;
    end else begin
      if (is_act && sel_active) err_flags[0] <= 1'b1;
      if ((is_rd || is_wr) && !sel_active) err_flags[1] <= 1'b1;
      if ((is_lmr || is_ref) && (bank_active != 4'b0000)) err_flags[2] <= 1'b1;
      if ((do_rd || do_wr) && !init_done) err_flags[3] <= 1'b1;
      if ((do_rd || do_wr) && (trcd_cnt[sdram_ba] != 4'd0)) err_flags[4] <= 1'b1;
      if (do_wr && sdram_dq_oe) err_flags[5] <= 1'b1;
      if (is_pre && sdram_a[10]) init_armed <= 1'b1;
      if (is_lmr) begin
        mode_reg <= sdram_a;
        if (init_armed) init_done <= 1'b1;
      end
      if (is_ref && (refresh_cnt != 16'hFFFF)) refresh_cnt <= refresh_cnt + 16'd1;
    end
  end

  // CAS-latency pipe; advances regardless of cke so in-flight reads complete.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_vld     <= 3'b000;
      for (int i = 0; i < 3; i++) pipe_data[i] <= 16'd0;
      sdram_dq_out <= 16'd0;
      sdram_dq_oe  <= 1'b0;
    end else begin
      sdram_dq_oe <= pipe_vld[0];
      if (pipe_vld[0]) sdram_dq_out <= pipe_data[0];
      pipe_vld     <= {1'b0, pipe_vld[2:1]};
      pipe_data[0] <= pipe_data[1];
      pipe_data[1] <= pipe_data[2];
      pipe_data[2] <= 16'd0;
      if (do_rd) begin
        pipe_vld[ins_slot]  <= 1'b1;
        pipe_data[ins_slot] <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_sdram_chip_model.sv
// tb/tb_sdram_chip_model.sv - scoreboard bench for the SDRAM target model
module tb_sdram_chip_model;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] RD  = 4'b0101;
  localparam logic [3:0] WR  = 4'b0100;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] REF = 4'b0001;
  localparam logic [3:0] LMR = 4'b0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sdram_cke = 1'b1;
  logic        sdram_ncs = 1'b0, sdram_nras = 1'b1, sdram_ncas = 1'b1, sdram_nwe = 1'b1;
  logic [1:0]  sdram_ba = 2'd0;
  logic [12:0] sdram_a = 13'd0;
  logic        sdram_dqml = 1'b0, sdram_dqmh = 1'b0;
  logic [15:0] sdram_dq_in = 16'd0;
  logic [15:0] sdram_dq_out;
  logic        sdram_dq_oe;
  logic [12:0] mode_reg;
  logic        init_done;
  logic [5:0]  err_flags;
  logic [15:0] refresh_cnt;

  typedef struct {
    logic [15:0] data;
    int          edge_at;
  } exp_t;

  exp_t sb[$];
  exp_t head;
  int   n_tests = 0;
  int   n_fail = 0;
  int   edge_n = 0;
  int   last_edge = 0;

  sdram_chip_model #(.MEM_AW(16), .TRCD(3)) dut (
    .clk(clk), .reset(reset), .sdram_cke(sdram_cke),
    .sdram_ncs(sdram_ncs), .sdram_nras(sdram_nras), .sdram_ncas(sdram_ncas), .sdram_nwe(sdram_nwe),
    .sdram_ba(sdram_ba), .sdram_a(sdram_a), .sdram_dqml(sdram_dqml), .sdram_dqmh(sdram_dqmh),
    .sdram_dq_in(sdram_dq_in), .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe),
    .mode_reg(mode_reg), .init_done(init_done), .err_flags(err_flags), .refresh_cnt(refresh_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n = edge_n + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every driven data cycle must match the oldest outstanding read, on its exact edge.
  always @(negedge clk) begin
    if (sdram_dq_oe === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_oe", {31'd0, sdram_dq_oe}, 32'd0);
      end else begin
        head = sb.pop_front();
        check("rd_data", {16'd0, sdram_dq_out}, {16'd0, head.data});
        check("rd_edge", edge_n, head.edge_at);
      end
    end
  end

  task automatic cmd(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                     input logic [15:0] dq = 16'd0, input logic [1:0] dqm = 2'b00);
    {sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe} = c;
    sdram_ba = ba;
    sdram_a = a;
    sdram_dq_in = dq;
    {sdram_dqmh, sdram_dqml} = dqm;
    @(posedge clk);
    #1;
    last_edge = edge_n;
    {sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe} = NOP;
    {sdram_dqmh, sdram_dqml} = 2'b00;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) cmd(NOP, 2'd0, 13'd0);
  endtask

  task automatic rd(input logic [1:0] ba, input logic [12:0] a, input logic [15:0] exp, input int cl);
    exp_t e;
    cmd(RD, ba, a);
    e.data = exp;
    e.edge_at = last_edge + cl - 1;
    sb.push_back(e);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_dq_oe", {31'd0, sdram_dq_oe}, 32'd0);
    check("rst_dq_out", {16'd0, sdram_dq_out}, 32'd0);
    check("rst_mode_reg", {19'd0, mode_reg}, 32'd0);
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_err", {26'd0, err_flags}, 32'd0);
    check("rst_refresh", {16'd0, refresh_cnt}, 32'd0);

    // init sequence
    cmd(PRE, 2'd0, 13'h400);
    for (int i = 0; i < 8; i++) cmd(REF, 2'd0, 13'd0);
    cmd(LMR, 2'd0, 13'h020);
    nop(1);
    check("init_done", {31'd0, init_done}, 32'd1);
    check("init_mode_reg", {19'd0, mode_reg}, 32'h020);
    check("init_refresh", {16'd0, refresh_cnt}, 32'd8);
    check("init_err", {26'd0, err_flags}, 32'd0);

    // CL2 write/read with auto-precharge, then read to the now-idle bank
    cmd(ACT, 2'd1, 13'h155);
    nop(2);
    cmd(WR, 2'd1, 13'h0AA, 16'hBEEF);
    rd(2'd1, 13'h4AA, 16'hBEEF, 2);
    nop(4);
    check("clean_err", {26'd0, err_flags}, 32'd0);
    cmd(RD, 2'd1, 13'h0AA);
    nop(4);
    check("idle_rd_err", {26'd0, err_flags}, 32'h02);

    // byte masks
    cmd(ACT, 2'd0, 13'h010);
    nop(2);
    cmd(WR, 2'd0, 13'h005, 16'h1234);
    cmd(WR, 2'd0, 13'h005, 16'hABCD, 2'b01);
    rd(2'd0, 13'h005, 16'hAB34, 2);
    nop(2);
    cmd(WR, 2'd0, 13'h006, 16'h1234);
    cmd(WR, 2'd0, 13'h006, 16'hABCD, 2'b10);
    rd(2'd0, 13'h406, 16'h12CD, 2);
    nop(3);
    check("mask_err", {26'd0, err_flags}, 32'h02);

    // tRCD violation still returns data
    cmd(ACT, 2'd2, 13'h020);
    nop(2);
    cmd(WR, 2'd2, 13'h001, 16'h5A5A);
    cmd(PRE, 2'd2, 13'h000);
    cmd(ACT, 2'd2, 13'h020);
    rd(2'd2, 13'h401, 16'h5A5A, 2);
    nop(3);
    check("trcd_err", {26'd0, err_flags}, 32'h12);

    // refresh with an open bank
    cmd(ACT, 2'd3, 13'h001);
    cmd(REF, 2'd0, 13'd0);
    cmd(PRE, 2'd0, 13'h400);
    nop(1);
    check("ref_open_err", {26'd0, err_flags}, 32'h16);
    check("refresh_9", {16'd0, refresh_cnt}, 32'd9);

    // double ACT and bus conflict
    cmd(ACT, 2'd0, 13'h002);
    cmd(ACT, 2'd0, 13'h002);
    nop(2);
    cmd(WR, 2'd0, 13'h003, 16'h7777);
    rd(2'd0, 13'h003, 16'h7777, 2);
    nop(1);
    cmd(WR, 2'd0, 13'h004, 16'h0000);
    cmd(PRE, 2'd0, 13'h400);
    nop(3);
    check("conflict_err", {26'd0, err_flags}, 32'h37);

    // CL3 with back-to-back reads
    cmd(LMR, 2'd0, 13'h030);
    nop(1);
    check("cl3_mode_reg", {19'd0, mode_reg}, 32'h030);
    cmd(ACT, 2'd1, 13'h0F0);
    nop(2);
    cmd(WR, 2'd1, 13'h010, 16'h1111);
    cmd(WR, 2'd1, 13'h011, 16'h2222);
    rd(2'd1, 13'h010, 16'h1111, 3);
    rd(2'd1, 13'h011, 16'h2222, 3);
    nop(5);
    check("cl3_sb_drained", sb.size(), 32'd0);

    // reset lands on the first data edge: nothing may be driven
    cmd(RD, 2'd1, 13'h010);
    cmd(RD, 2'd1, 13'h011);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_oe", {31'd0, sdram_dq_oe}, 32'd0);
    reset = 1'b0;
    nop(5);
    check("post_rst_oe", {31'd0, sdram_dq_oe}, 32'd0);
    check("post_rst_err", {26'd0, err_flags}, 32'd0);
    check("post_rst_init", {31'd0, init_done}, 32'd0);
    check("post_rst_mode", {19'd0, mode_reg}, 32'd0);
    check("sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
